// File: rtl/ds_pkg.sv
// ds_pkg
// Shared definitions for the delta-sigma sample framer:
//   state_t            frame FSM state encoding
//   FRAME_LEN          bytes per frame (5 with DS_FRAMER_SEQ_EN defined, else 4)
//   SYNC_BYTE_DEFAULT  default first byte of every frame
// Build option: DS_FRAMER_SEQ_EN appends an 8-bit sequence byte to every frame.
package ds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_B2   = 3'd2,
        ST_B1   = 3'd3,
        ST_B0   = 3'd4,
        ST_SEQ  = 3'd5
    } state_t;

`ifdef DS_FRAMER_SEQ_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/ds_sample_fifo.sv
// ds_sample_fifo
// Synchronous sample FIFO with occupancy count.
//   clk, rst_n   system clock, asynchronous active-low reset
//   push         write request; accepted when not full, or when full and popping
//   push_data    sample to write
//   pop          read request; ignored when empty
//   pop_data     head-of-FIFO sample (valid while !empty)
//   full, empty  occupancy flags derived from level
//   level        entries currently stored, updated the cycle after push/pop
module ds_sample_fifo
    import ds_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) level_d = level_q + LW'(1);
        else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ds_sample_framer.sv
// ds_sample_framer
// Captures decimated samples on sample_clk rising edges, buffers them and
// emits frames {SYNC_BYTE, S[23:16], S[15:8], S[7:0]} (S zero-extended to
// 24 bits) on a valid/ready byte stream. With DS_FRAMER_SEQ_EN defined a fifth
// byte carries an 8-bit frame sequence counter.
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           enables new captures (buffered samples always drain)
//   sample_clk   decimated clock, asynchronous to clk
//   sample_in    decimated sample, stable several clk after sample_clk rise
//   tx_data      current frame byte
//   tx_valid     tx_data valid; byte taken when tx_valid & tx_ready
//   tx_ready     consumer ready
//   overflow     sticky: a sample was dropped on a full FIFO
//   ovf_clr      single-cycle clear of overflow (a same-cycle drop wins)
//   fifo_level   samples currently buffered
//
// state   | meaning
// IDLE    | no frame in flight, waiting for a buffered sample
// SYNC    | presenting SYNC_BYTE
// B2      | presenting S[23:16]
// B1      | presenting S[15:8]
// B0      | presenting S[7:0]
// SEQ     | presenting sequence counter (DS_FRAMER_SEQ_EN only)
module ds_sample_framer
    import ds_pkg::*;
#(
    parameter int         DATA_W     = 20,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_clk,
    input  logic [DATA_W-1:0] sample_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [LW-1:0]     fifo_level
);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              prev_q, prev_d;
    logic              cap;
    logic              ovf_q, ovf_d;
    state_t            state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              accept;
    logic              frame_done;
    logic              load_frame;
`ifdef DS_FRAMER_SEQ_EN
    logic [7:0]        seq_q, seq_d;
`endif

    ds_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap),
        .push_data (sample_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = ovf_q;
    assign accept   = tx_valid_q & tx_ready;

    // Capture lands three clk after the sample_clk rise, by which time
    // sample_in has settled.
    assign cap = s2_q & ~prev_q & en;

    always_comb begin
        s1_d   = sample_clk;
        s2_d   = s1_q;
        prev_d = s2_q;
        ovf_d  = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (cap && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        load_frame = 1'b0;
`ifdef DS_FRAMER_SEQ_EN
        seq_d      = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load_frame = 1'b1;
            end
            ST_SYNC: begin
                if (accept) begin
                    tx_data_d = shift_q[23:16];
                    state_d   = ST_B2;
                end
            end
            ST_B2: begin
                if (accept) begin
                    tx_data_d = shift_q[15:8];
                    state_d   = ST_B1;
                end
            end
            ST_B1: begin
                if (accept) begin
                    tx_data_d = shift_q[7:0];
                    state_d   = ST_B0;
                end
            end
            ST_B0: begin
                if (accept) begin
`ifdef DS_FRAMER_SEQ_EN
                    tx_data_d = seq_q;
                    state_d   = ST_SEQ;
`else
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef DS_FRAMER_SEQ_EN
            ST_SEQ: begin
                if (accept) begin
                    seq_d      = seq_q + 8'd1;
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Last byte taken: chain straight into the next frame if one is waiting.
        if (frame_done) begin
            if (!fifo_empty) begin
                load_frame = 1'b1;
            end else begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end

        if (load_frame) begin
            fifo_pop   = 1'b1;
            shift_d    = 24'(fifo_rd_data);
            tx_data_d  = SYNC_BYTE;
            tx_valid_d = 1'b1;
            state_d    = ST_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            prev_q     <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef DS_FRAMER_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_q <= '0;
        else        seq_q <= seq_d;
    end
`endif

endmodule

// File: tb/tb_ds_sample_framer.sv
module tb_ds_sample_framer;
    import ds_pkg::*;

    localparam int DATA_W = 20;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              sample_clk;
    logic [DATA_W-1:0] sample_in;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              overflow;
    logic              ovf_clr;
    logic [LW-1:0]     fifo_level;

    always #5 clk = ~clk;

    ds_sample_framer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sample_clk (sample_clk),
        .sample_in  (sample_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [DATA_W-1:0] s;
        logic [7:0]        b2;
        logic [7:0]        b1;
        logic [7:0]        b0;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    logic [7:0] seq_m;
    logic [7:0] mon_e;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_bytes(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(b2);
        exp_q.push_back(b1);
        exp_q.push_back(b0);
`ifdef DS_FRAMER_SEQ_EN
        exp_q.push_back(seq_m);
        seq_m = seq_m + 8'd1;
`endif
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] v);
        logic [23:0] s;
        s = 24'(v);
        push_bytes(s[23:16], s[15:8], s[7:0]);
    endtask

    // One sample_clk period of 8 clk; optional ovf_clr aligned with the capture cycle.
    task automatic pulse(input logic [DATA_W-1:0] v, input bit clr);
        sample_in  = v;
        sample_clk = 1'b1;
        cyc(2);
        if (clr) ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        cyc(1);
        sample_clk = 1'b0;
        cyc(4);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic gap_check(input string name, input int ncyc);
        int gaps;
        gaps = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (!tx_valid) gaps++;
        end
        chk(name, 32'(gaps), 32'd0);
    endtask

    // Scoreboard: every byte the consumer takes is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got %02h expected none", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(mon_e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{20'h00000, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{20'hFFFFF, 8'h0F, 8'hFF, 8'hFF};
        vecs[2] = '{20'h12345, 8'h01, 8'h23, 8'h45};
        vecs[3] = '{20'h80001, 8'h08, 8'h00, 8'h01};
        vecs[4] = '{20'h5A5A5, 8'h05, 8'hA5, 8'hA5};

        seq_m      = 8'd0;
        rst_n      = 1'b0;
        en         = 1'b1;
        sample_clk = 1'b0;
        sample_in  = '0;
        tx_ready   = 1'b0;
        ovf_clr    = 1'b0;
        cyc(3);
        chk("rst_tx_data",  32'(tx_data),    32'd0);
        chk("rst_tx_valid", 32'(tx_valid),   32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_level",    32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Single sample, consumer always ready: level goes 1 then 0 as the frame starts.
        tx_ready = 1'b1;
        push_bytes(8'h0A, 8'hBC, 8'hDE);
        sample_in  = 20'hABCDE;
        sample_clk = 1'b1;
        begin
            int k;
            k = 0;
            while (fifo_level != LW'(1) && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t1_level_up", 32'(fifo_level), 32'd1);
        @(negedge clk);
        chk("t1_level_down", 32'(fifo_level), 32'd0);
        chk("t1_valid_up",   32'(tx_valid),   32'd1);
        @(posedge clk);
        #2;
        sample_clk = 1'b0;
        cyc(4);
        wait_drain(100);
        chk("t1_valid_low", 32'(tx_valid), 32'd0);

        // Table of sample values with expected payload bytes.
        for (int i = 0; i < 5; i++) begin
            push_bytes(vecs[i].b2, vecs[i].b1, vecs[i].b0);
            pulse(vecs[i].s, 1'b0);
            wait_drain(100);
            chk("vec_valid_low", 32'(tx_valid),   32'd0);
            chk("vec_level",     32'(fifo_level), 32'd0);
        end

        // Stall five cycles while BC is presented.
        tx_ready = 1'b0;
        push_bytes(8'h0A, 8'hBC, 8'hDE);
        pulse(20'hABCDE, 1'b0);
        tx_ready = 1'b1;
        cyc(2);
        tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data",  32'(tx_data),  32'hBC);
            chk("stall_valid", 32'(tx_valid), 32'd1);
        end
        @(posedge clk);
        #2;
        tx_ready = 1'b1;
        wait_drain(100);

        // en=0 blocks capture but buffered samples still drain.
        en = 1'b0;
        pulse(20'h13579, 1'b0);
        chk("en0_level", 32'(fifo_level), 32'd0);
        chk("en0_valid", 32'(tx_valid),   32'd0);
        en = 1'b1;
        tx_ready = 1'b0;
        push_frame(20'h11111);
        pulse(20'h11111, 1'b0);
        push_frame(20'h22222);
        pulse(20'h22222, 1'b0);
        en = 1'b0;
        tx_ready = 1'b1;
        wait_drain(100);
        chk("en0_drain_level", 32'(fifo_level), 32'd0);
        en = 1'b1;

        // Fill: the first sample moves into the frame register, 16 more fill the
        // FIFO, the 18th is dropped.
        tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) push_frame(20'h0C000 | 20'(i));
            pulse(20'h0C000 | 20'(i), 1'b0);
        end
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_set",   32'(overflow),   32'd1);

        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Clear in the very cycle a drop happens: the drop wins.
        pulse(20'h0DEAD, 1'b1);
        chk("ovf_clr_vs_drop", 32'(overflow),   32'd1);
        chk("ovf_level_hold",  32'(fifo_level), 32'd16);

        tx_ready = 1'b1;
        gap_check("ovf_no_gap", 17 * FRAME_LEN);
        wait_drain(200);
        chk("ovf_drain_valid", 32'(tx_valid), 32'd0);
        chk("ovf_sticky",      32'(overflow), 32'd1);

        // Reset during B2 discards the frame and the buffered samples.
        tx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        pulse(20'h11223, 1'b0);
        pulse(20'h33333, 1'b0);
        pulse(20'h44444, 1'b0);
        tx_ready = 1'b1;
        cyc(1);
        tx_ready = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        chk("pre_rst_valid", 32'(tx_valid),   32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        seq_m = 8'd0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_valid",    32'(tx_valid),   32'd0);
        chk("post_rst_level",    32'(fifo_level), 32'd0);
        chk("post_rst_overflow", 32'(overflow),   32'd0);
        chk("post_rst_data",     32'(tx_data),    32'd0);
        tx_ready = 1'b1;
        cyc(4);
        chk("post_rst_no_stale", 32'(tx_valid), 32'd0);
        push_frame(20'h54321);
        pulse(20'h54321, 1'b0);
        wait_drain(100);

        // Three frames back-to-back from a fresh reset.
        rst_n = 1'b0;
        seq_m = 8'd0;
        cyc(2);
        rst_n = 1'b1;
        tx_ready = 1'b0;
        cyc(2);
        push_frame(20'h00001);
        pulse(20'h00001, 1'b0);
        push_frame(20'h00002);
        pulse(20'h00002, 1'b0);
        push_frame(20'h00003);
        pulse(20'h00003, 1'b0);
        tx_ready = 1'b1;
        gap_check("b2b_no_gap", 3 * FRAME_LEN);
        wait_drain(100);
        chk("b2b_valid_low", 32'(tx_valid), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
